// File: rtl/msdf_pkg.sv
// rtl/msdf_pkg.sv - shared MSDF digit encoding and legality helper
package msdf_pkg;

    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_NEG  = 2'b11;

    // 2'b10 is the only unused code of the signed-digit encoding
    function automatic logic digit_legal(input logic [1:0] d);
        return (d != 2'b10);
    endfunction

endpackage

// File: rtl/msdf_otf_converter_otf_step.sv
// rtl/msdf_otf_converter_otf_step.sv - one on-the-fly conversion step (Q, QM, digit -> Q', QM')
module otf_step
    import msdf_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next,
    output logic         illegal
);

    // Append one digit; QM tracks Q-1 so a negative digit never needs a borrow chain
    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        illegal = !digit_legal(digit);
        case (digit)
            DIG_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            DIG_NEG: begin
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            default: begin
                // zero digit, and illegal digits which are treated as zero
                q_next  = {q[W-2:0], 1'b0};
                qm_next = {qm[W-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/msdf_otf_converter.sv
// rtl/msdf_otf_converter.sv - MSDF digit stream to two's-complement parallel converter
module msdf_otf_converter
    import msdf_pkg::*;
#(
    parameter int N    = 8,
    parameter int SKIP = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [1:0]   in_digit,
    output logic         busy,
    output logic         out_valid,
    output logic [N:0]   result,
    output logic         digit_err
);

    localparam int CNT_MAX = (N > SKIP) ? N : SKIP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SKIP_LAST = (SKIP > 0) ? CW'(SKIP - 1) : '0;
    localparam logic [CW-1:0] N_LAST    = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N:0]    q_q, q_d;
    logic [N:0]    qm_q, qm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic          digit_err_q, digit_err_d;

    logic [N:0]    step_q;
    logic [N:0]    step_qm;
    logic          step_illegal;

    otf_step #(.W(N + 1)) u_step (
        .q       (q_q),
        .qm      (qm_q),
        .digit   (in_digit),
        .q_next  (step_q),
        .qm_next (step_qm),
        .illegal (step_illegal)
    );

    // Next-state and datapath selection; start overrides every state
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        qm_d        = qm_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        digit_err_d = digit_err_q;
        if (start) begin
            state_d     = (SKIP > 0) ? ST_SKIP : ST_CONV;
            q_d         = '0;
            qm_d        = '1;
            cnt_d       = '0;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
            digit_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_SKIP: begin
                    if (in_valid) begin
                        if (!digit_legal(in_digit)) begin
                            digit_err_d = 1'b1;
                        end
                        if (cnt_q == SKIP_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_CONV;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_CONV: begin
                    if (in_valid) begin
                        q_d   = step_q;
                        qm_d  = step_qm;
                        cnt_d = cnt_q + 1'b1;
                        if (step_illegal) begin
                            digit_err_d = 1'b1;
                        end
                        if (cnt_q == N_LAST) begin
                            state_d     = ST_DONE;
                            busy_d      = 1'b0;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE ignore the digit stream
                end
            endcase
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            qm_q        <= '1;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            qm_q        <= qm_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            digit_err_q <= digit_err_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = q_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_msdf_otf_converter.sv
// tb/tb_msdf_otf_converter.sv - self-checking bench for msdf_otf_converter
module tb_msdf_otf_converter;

    localparam int NN = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [1:0]   in_digit;
    logic         busy_o      [2];
    logic         out_valid_o [2];
    logic [NN:0]  result_o    [2];
    logic         digit_err_o [2];

    int total;
    int bad;

    // reference model: integer value of the accumulated fraction digits
    bit m_act  [2];
    bit m_done [2];
    bit m_err  [2];
    int m_nacc [2];
    int m_qv   [2];

    msdf_otf_converter #(.N(NN), .SKIP(3)) u_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_digit  (in_digit),
        .busy      (busy_o[0]),
        .out_valid (out_valid_o[0]),
        .result    (result_o[0]),
        .digit_err (digit_err_o[0])
    );

    msdf_otf_converter #(.N(NN), .SKIP(0)) u_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_digit  (in_digit),
        .busy      (busy_o[1]),
        .out_valid (out_valid_o[1]),
        .result    (result_o[1]),
        .digit_err (digit_err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int skip_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    function automatic int dval(input logic [1:0] d);
        if (d == 2'b01) return 1;
        if (d == 2'b11) return -1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k]  = 1'b0;
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
            m_nacc[k] = 0;
            m_qv[k]   = 0;
        end
    endtask

    task automatic model_step(input logic st, input logic v, input logic [1:0] d);
        for (int k = 0; k < 2; k++) begin
            if (st) begin
                m_act[k]  = 1'b1;
                m_done[k] = 1'b0;
                m_err[k]  = 1'b0;
                m_nacc[k] = 0;
                m_qv[k]   = 0;
            end else if (m_act[k] && !m_done[k] && v) begin
                if (d == 2'b10) m_err[k] = 1'b1;
                if (m_nacc[k] >= skip_of(k)) m_qv[k] = m_qv[k] * 2 + dval(d);
                m_nacc[k]++;
                if (m_nacc[k] == skip_of(k) + NN) m_done[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] t;
        for (int k = 0; k < 2; k++) begin
            t = m_qv[k];
            check_eq($sformatf("%s_busy%0d", tag, k), 32'(busy_o[k]), 32'(m_act[k] && !m_done[k]));
            check_eq($sformatf("%s_oval%0d", tag, k), 32'(out_valid_o[k]), 32'(m_done[k]));
            check_eq($sformatf("%s_err%0d", tag, k), 32'(digit_err_o[k]), 32'(m_err[k]));
            check_eq($sformatf("%s_res%0d", tag, k), 32'(result_o[k]), 32'(t[NN:0]));
        end
    endtask

    task automatic cycle(input string tag, input logic st, input logic v, input logic [1:0] d);
        start    = st;
        in_valid = v;
        in_digit = d;
        @(posedge clk);
        #1;
        model_step(st, v, d);
        check_all(tag);
        start    = 1'b0;
        in_valid = 1'b0;
        in_digit = 2'b00;
    endtask

    task automatic dig(input string tag, input logic [1:0] d);
        cycle(tag, 1'b0, 1'b1, d);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 2'b00);
    endtask

    function automatic logic [1:0] rand_legal();
        int r;
        r = $urandom_range(0, 2);
        if (r == 0) return 2'b00;
        if (r == 1) return 2'b01;
        return 2'b11;
    endfunction

    initial begin
        logic [1:0] stream [4];
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_digit = 2'b00;
        model_reset();
        #2;
        check_all("reset");
        #10;
        rst = 1'b1;

        // SKIP=3 instance: three junk digits then +1,-1,0,+1
        stream[0] = 2'b01; stream[1] = 2'b11; stream[2] = 2'b00; stream[3] = 2'b01;
        cycle("t1_start", 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) dig("t1_junk", rand_legal());
        for (int i = 0; i < 4; i++) dig("t1_dig", stream[i]);
        check_eq("t1_result", 32'(result_o[0]), 32'h05);
        check_eq("t1_oval", 32'(out_valid_o[0]), 32'h1);
        check_eq("t1_busy", 32'(busy_o[0]), 32'h0);
        idle("t1_hold", 3);
        dig("t1_ignored", 2'b11);
        check_eq("t1_hold_res", 32'(result_o[0]), 32'h05);

        // SKIP=0 instance: all -1, then +1,0,0,0
        cycle("t2_start", 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) dig("t2_neg", 2'b11);
        check_eq("t2_neg_res", 32'(result_o[1]), 32'h11);
        cycle("t2_start2", 1'b1, 1'b1, 2'b11);
        dig("t2_pos", 2'b01);
        for (int i = 0; i < 3; i++) dig("t2_zero", 2'b00);
        check_eq("t2_pos_res", 32'(result_o[1]), 32'h08);

        // first stream again with two idle cycles between digits
        cycle("t3_start", 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            dig("t3_junk", rand_legal());
            idle("t3_gap", 2);
        end
        for (int i = 0; i < 4; i++) begin
            dig("t3_dig", stream[i]);
            idle("t3_gap", 2);
        end
        check_eq("t3_result", 32'(result_o[0]), 32'h05);

        // illegal digit in the second converted slot
        cycle("t4_start", 1'b1, 1'b0, 2'b00);
        dig("t4_d0", 2'b01);
        dig("t4_d1", 2'b10);
        dig("t4_d2", 2'b01);
        dig("t4_d3", 2'b01);
        check_eq("t4_result", 32'(result_o[1]), 32'h0b);
        check_eq("t4_err", 32'(digit_err_o[1]), 32'h1);
        cycle("t4_restart", 1'b1, 1'b0, 2'b00);
        check_eq("t4_err_clr", 32'(digit_err_o[1]), 32'h0);

        // asynchronous reset mid-conversion
        cycle("t5_start", 1'b1, 1'b0, 2'b00);
        dig("t5_d0", 2'b01);
        dig("t5_d1", 2'b11);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t5_async");
        check_eq("t5_busy", 32'(busy_o[1]), 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) dig("t5_post", 2'b01);
        check_eq("t5_post_res", 32'(result_o[1]), 32'h00);

        // restart mid-conversion must not leak the aborted digits
        cycle("t6_start", 1'b1, 1'b0, 2'b00);
        dig("t6_a0", 2'b01);
        dig("t6_a1", 2'b11);
        cycle("t6_restart", 1'b1, 1'b0, 2'b00);
        dig("t6_d0", 2'b00);
        dig("t6_d1", 2'b00);
        dig("t6_d2", 2'b00);
        dig("t6_d3", 2'b01);
        check_eq("t6_result", 32'(result_o[1]), 32'h01);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       st;
            logic       v;
            logic [1:0] d;
            st = ($urandom_range(0, 14) == 0);
            v  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 15) == 0) ? 2'b10 : rand_legal();
            cycle("rnd", st, v, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
